adc_chan_averager: RTL
======================

Name: adc_chan_averager

Overview:
- Sits directly downstream of the 8-channel serial ADC front end in the same clk domain.
- Paces acquisition sweeps by issuing sync pulses to the front end.
- Captures each tagged 12-bit sample, accumulates 2^AVG_LOG2 samples per channel, and publishes per-channel averages.
- Exposes a registered readout port, a frame-done pulse and per-channel window alarms to the control logic.

Parameters:
- AVG_LOG2, 3, log2 of samples averaged per channel; legal range 0..6.
- SWEEP_PERIOD, 2000, clk cycles between sync requests; minimum 16.
- NUM_CH, 8, channel count; fixed at 8, since sample_chan is 3 bits.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_l  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = sweep timer runs; 0 = timer cleared, no new sync.
- sync  out  1  one-cycle pulse starting an ADC sweep.
- adc_busy  in  1  front end mid-sweep; sync never issued while high.
- sample_valid  in  1  one-cycle strobe: sample_data/sample_chan are valid.
- sample_data  in  12  raw ADC code.
- sample_chan  in  3  channel tag of sample_data.
- clear  in  1  synchronous flush of accumulators, counters, flags.
- rd_addr  in  3  channel to read.
- rd_data  out  12  averaged value of rd_addr, registered.
- new_flags  out  8  bit n set when ch n result updated since last read of ch n.
- frame_done  out  1  one-cycle pulse when all 8 results updated in the current frame.
- alarm_lo  out  8  bit n: latest avg of ch n < thr_lo.
- alarm_hi  out  8  bit n: latest avg of ch n > thr_hi.
- thr_lo, thr_hi  in  12 each  unsigned alarm window, quasi-static.
- missed_sync  out  8  saturating count of timer expiries while a request was already pending.

Behaviour:
- Reset values (rst_l low, async):
  - All outputs 0, including sync, rd_data, new_flags, frame_done, alarms and missed_sync.
  - Accumulators, sample counters, results and timer are also 0.
- Sweep timer:
  - Counts 0..SWEEP_PERIOD-1 while enable=1, then wraps to 0 and sets req_pending.
  - sync pulses for one cycle when req_pending=1 and adc_busy=0; req_pending clears in the same cycle.
  - If the timer expires while req_pending is already 1, missed_sync increments, saturating at 255.
  - enable=0 clears the timer and req_pending. The state machine in progress is not aborted.
- Sync FSM states: IDLE, WAIT_BUSY, ARMED.
  - IDLE -> WAIT_BUSY on timer expiry.
  - WAIT_BUSY -> ARMED when adc_busy=0; sync is asserted in this transition cycle.
  - ARMED -> IDLE once adc_busy is seen high, or after 16 cycles with adc_busy never rising (lost-start timeout).
- Accumulate path (2-stage pipeline):
  - Stage 1 registers sample_data and sample_chan on sample_valid.
  - Stage 2 adds the sample into acc[chan] (12+AVG_LOG2 bits, no overflow possible) and increments cnt[chan].
  - When cnt[chan] reaches 2^AVG_LOG2-1 with a sample in stage 2:
    - result[chan] = (acc+sample) >> AVG_LOG2, truncating.
    - acc[chan] and cnt[chan] reset to 0.
    - new_flags[chan], alarm_lo[chan] and alarm_hi[chan] update.
  - Latency from sample_valid to updated result and flags: 2 cycles.
  - Back-to-back sample_valid on the same channel in consecutive cycles is required to work. Stage-2 forwarding is mandatory; no sample may be lost.
- Frame tracking:
  - An 8-bit upd mask sets bit n on each result update of ch n.
  - When the mask reaches 0xFF, frame_done pulses on the next cycle and the mask clears.
  - If an update occurs in the same cycle the mask clears, that bit is retained.
- Readout:
  - rd_data = result[rd_addr] registered, 1-cycle latency.
  - A read clears new_flags[rd_addr] the cycle after rd_addr is presented. rd_addr is sampled every cycle, so any change counts as a read.
  - If a result update and a read clear hit the same channel in the same cycle, the update wins and the flag stays 1.
- clear:
  - Zeros acc, cnt, upd mask and new_flags; discards any in-flight pipeline sample.
  - Keeps result, alarms and missed_sync.
  - clear takes priority over sample_valid in the same cycle.
- Reset mid-operation: async clear of everything; sync must be 0 within the reset assertion, with no glitch pulse afterwards.

Decomposition:
- Package adc_avg_pkg holds NUM_CH, SAMPLE_W=12, CHAN_W=3, the FSM state encoding (IDLE/WAIT_BUSY/ARMED) and the ARM_TIMEOUT=16 constant.
- One sub-module, adc_sweep_timer: timer, sync FSM and missed_sync counter.
- The accumulate/readout path stays in the top.

Test Plan:
1. AVG_LOG2=3; 8 sweeps of ch0..7, ch n always 100*n+7 -> result[n]=100*n+7; frame_done pulses once; new_flags=0xFF; reading ch3 returns 307 next cycle and clears bit 3.
2. Ch5 samples 0,1,2,...,7 back-to-back every cycle -> result[5]=3 (28>>3); no sample lost; cnt[5]=0 afterwards.
3. SWEEP_PERIOD=16, adc_busy held high for 40 cycles -> exactly one sync, issued the first cycle busy=0; missed_sync=1.
4. thr_lo=200, thr_hi=3000; ch2 averages 150 then 3500 -> alarm_lo[2]=1, then alarm_lo[2]=0 and alarm_hi[2]=1.
5. clear asserted with 4 of 8 samples accumulated on ch1, then 8 samples of 40 -> result[1]=40, no contamination from earlier samples.
6. rst_l dropped mid-accumulation while sync is pending -> all outputs 0 immediately; first sync occurs SWEEP_PERIOD cycles after release with enable=1.

Source files
------------

// File: rtl/adc_chan_averager_pkg.sv
// Shared constants and types for the ADC channel averager and its sweep timer.
package adc_avg_pkg;

    localparam int NUM_CH      = 8;
    localparam int SAMPLE_W    = 12;
    localparam int CHAN_W      = 3;
    localparam int ARM_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        ARMED     = 2'd2
    } sync_state_e;

    typedef struct packed {
        logic                vld;
        logic [CHAN_W-1:0]   chan;
        logic [SAMPLE_W-1:0] data;
    } sample_req_t;

    function automatic logic [NUM_CH-1:0] chan_onehot(input logic en, input logic [CHAN_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[ch] = en;
        return v;
    endfunction

endpackage

// File: rtl/adc_chan_averager_if.sv
// Bundle between the averager, the ADC front end and the control logic.
interface adc_chan_averager_if;
    import adc_avg_pkg::*;

    logic                enable;
    logic                sync;
    logic                adc_busy;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic [CHAN_W-1:0]   sample_chan;
    logic                clear;
    logic [CHAN_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_data;
    logic [NUM_CH-1:0]   new_flags;
    logic                frame_done;
    logic [NUM_CH-1:0]   alarm_lo;
    logic [NUM_CH-1:0]   alarm_hi;
    logic [SAMPLE_W-1:0] thr_lo;
    logic [SAMPLE_W-1:0] thr_hi;
    logic [7:0]          missed_sync;

    modport slave (
        input  enable, adc_busy, sample_valid, sample_data, sample_chan,
               clear, rd_addr, thr_lo, thr_hi,
        output sync, rd_data, new_flags, frame_done, alarm_lo, alarm_hi, missed_sync
    );

    modport master (
        output enable, adc_busy, sample_valid, sample_data, sample_chan,
               clear, rd_addr, thr_lo, thr_hi,
        input  sync, rd_data, new_flags, frame_done, alarm_lo, alarm_hi, missed_sync
    );

endinterface

// File: rtl/adc_chan_averager_sweep_timer.sv
// Sweep pacing: period timer, sync handshake FSM toward the front end and
// a saturating count of requests that expired while still unserviced.
module adc_sweep_timer
    import adc_avg_pkg::*;
#(
    parameter int SWEEP_PERIOD = 2000
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       i_enable,
    input  logic       i_adc_busy,
    output logic       o_sync,
    output logic [7:0] o_missed_sync
);

    localparam int TMR_W = $clog2(SWEEP_PERIOD);
    localparam int ARM_W = $clog2(ARM_TIMEOUT);

    sync_state_e      r_state;
    sync_state_e      w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [ARM_W-1:0] r_arm_cnt;
    logic             r_req_pending;
    logic [7:0]       r_missed;
    logic             w_expire;
    logic             w_sync;

    assign w_expire = i_enable && (r_tmr == TMR_W'(SWEEP_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_tmr <= '0;
        end else if (!i_enable || w_expire) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_req_pending <= 1'b0;
        end else if (!i_enable) begin
            r_req_pending <= 1'b0;
        end else if (w_expire) begin
            r_req_pending <= 1'b1;
        end else if (w_sync) begin
            r_req_pending <= 1'b0;
        end
    end

    // An expiry in the very cycle the pending request is serviced is not a miss.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_missed <= '0;
        end else if (w_expire && r_req_pending && !w_sync && (r_missed != 8'hFF)) begin
            r_missed <= r_missed + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_arm_cnt <= '0;
        end else if (r_state != ARMED) begin
            r_arm_cnt <= '0;
        end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

    // A request withdrawn by enable=0 drops WAIT_BUSY; an ARMED wait runs to its end.
    always_comb begin
        w_state_nxt = r_state;
        w_sync      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_req_pending || w_expire) w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!r_req_pending) begin
                    w_state_nxt = IDLE;
                end else if (!i_adc_busy) begin
                    w_sync      = 1'b1;
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (i_adc_busy || (r_arm_cnt == ARM_W'(ARM_TIMEOUT - 1))) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_sync        = w_sync;
    assign o_missed_sync = r_missed;

endmodule

// File: rtl/adc_chan_averager.sv
// Per-channel block averager behind the 8-channel ADC front end: accumulates
// 2^AVG_LOG2 samples per channel, publishes averages, flags, frame and alarms.
module adc_chan_averager
    import adc_avg_pkg::*;
#(
    parameter int AVG_LOG2     = 3,
    parameter int SWEEP_PERIOD = 2000
) (
    input logic                clk,
    input logic                rst_l,
    adc_chan_averager_if.slave bus
);

    localparam int               ACC_W    = SAMPLE_W + AVG_LOG2;
    localparam int               CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    sample_req_t                       r_s1;
    logic [NUM_CH-1:0][ACC_W-1:0]      r_acc;
    logic [NUM_CH-1:0][CNT_W-1:0]      r_cnt;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]   r_result;
    logic [NUM_CH-1:0]                 r_alarm_lo;
    logic [NUM_CH-1:0]                 r_alarm_hi;
    logic [NUM_CH-1:0]                 r_new_flags;
    logic [NUM_CH-1:0]                 r_upd_mask;
    logic                              r_frame_done;
    logic [CHAN_W-1:0]                 r_rd_addr_q;
    logic [SAMPLE_W-1:0]               r_rd_data;

    logic [ACC_W-1:0]                  w_sum;
    logic [SAMPLE_W-1:0]               w_avg;
    logic                              w_last;
    logic                              w_upd;
    logic                              w_rd;
    logic                              w_mask_full;
    logic [NUM_CH-1:0]                 w_upd_oh;
    logic [NUM_CH-1:0]                 w_rd_oh;

    adc_sweep_timer #(
        .SWEEP_PERIOD (SWEEP_PERIOD)
    ) u_sweep_timer (
        .clk           (clk),
        .rst_l         (rst_l),
        .i_enable      (bus.enable),
        .i_adc_busy    (bus.adc_busy),
        .o_sync        (bus.sync),
        .o_missed_sync (bus.missed_sync)
    );

    // Stage 1: capture the tagged sample; clear kills it on entry.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_s1 <= '0;
        end else begin
            r_s1.vld <= bus.sample_valid && !bus.clear;
            if (bus.sample_valid) begin
                r_s1.chan <= bus.sample_chan;
                r_s1.data <= bus.sample_data;
            end
        end
    end

    // Stage 2 reads and writes acc/cnt in the same cycle, so a sample on the
    // same channel right behind it already sees the updated accumulator.
    assign w_sum    = r_acc[r_s1.chan] + ACC_W'(r_s1.data);
    assign w_avg    = SAMPLE_W'(w_sum >> AVG_LOG2);
    assign w_last   = r_s1.vld && (r_cnt[r_s1.chan] == CNT_LAST);
    assign w_upd    = w_last && !bus.clear;
    assign w_upd_oh = chan_onehot(w_upd, r_s1.chan);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (bus.clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_s1.vld) begin
            if (w_last) begin
                r_acc[r_s1.chan] <= '0;
                r_cnt[r_s1.chan] <= '0;
            end else begin
                r_acc[r_s1.chan] <= w_sum;
                r_cnt[r_s1.chan] <= r_cnt[r_s1.chan] + 1'b1;
            end
        end
    end

    // Results and alarms survive clear; only a completed window rewrites them.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_result   <= '0;
            r_alarm_lo <= '0;
            r_alarm_hi <= '0;
        end else if (w_upd) begin
            r_result[r_s1.chan]   <= w_avg;
            r_alarm_lo[r_s1.chan] <= (w_avg < bus.thr_lo);
            r_alarm_hi[r_s1.chan] <= (w_avg > bus.thr_hi);
        end
    end

    // A read is any change of rd_addr from the previous cycle.
    assign w_rd        = (bus.rd_addr != r_rd_addr_q);
    assign w_rd_oh     = chan_onehot(w_rd, bus.rd_addr);
    assign w_mask_full = &r_upd_mask;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rd_addr_q  <= '0;
            r_rd_data    <= '0;
            r_new_flags  <= '0;
            r_upd_mask   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_addr_q <= bus.rd_addr;
            r_rd_data   <= r_result[bus.rd_addr];
            if (bus.clear) begin
                r_new_flags  <= '0;
                r_upd_mask   <= '0;
                r_frame_done <= 1'b0;
            end else begin
                r_new_flags  <= (r_new_flags & ~w_rd_oh) | w_upd_oh;
                r_frame_done <= w_mask_full;
                r_upd_mask   <= (w_mask_full ? '0 : r_upd_mask) | w_upd_oh;
            end
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.new_flags  = r_new_flags;
    assign bus.frame_done = r_frame_done;
    assign bus.alarm_lo   = r_alarm_lo;
    assign bus.alarm_hi   = r_alarm_hi;

endmodule
